// File: rtl/nes_clk_pkg.sv
// Shared types and default timing constants for the NES clock/reset controller.
// The defaults give the NTSC 12:4 master-clock division.
package nes_clk_pkg;

    localparam int unsigned DEF_CPU_DIV       = 12;
    localparam int unsigned DEF_PPU_DIV       = 4;
    localparam int unsigned DEF_M2_RISE       = 5;
    localparam int unsigned DEF_SETTLE_CYCLES = 1024;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        PAUSED    = 2'd3
    } clk_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_clk_ctrl.sv
// Master-clock sequencer: waits for a settled PLL lock, then produces CPU/PPU
// clock enables, the M2 phase and a synchronous system reset, with pause support.
module nes_clk_ctrl
    import nes_clk_pkg::*;
#(
    parameter int unsigned CPU_DIV       = DEF_CPU_DIV,
    parameter int unsigned PPU_DIV       = DEF_PPU_DIV,
    parameter int unsigned M2_RISE       = DEF_M2_RISE,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                       refclk,
    input  logic                       rst,
    input  logic                       pll_locked,
    input  logic                       pause_req,
    output logic                       pause_ack,
    output logic                       sys_rst,
    output logic                       cpu_ce,
    output logic                       ppu_ce,
    output logic                       m2,
    output logic [$clog2(CPU_DIV)-1:0] phase
);

    localparam int unsigned PHASE_W = cnt_width(CPU_DIV);
    localparam int unsigned CNT_W   = cnt_width(SETTLE_CYCLES);

    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(CPU_DIV - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    clk_state_e           state_q;
    clk_state_e           state_d;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   phase_d;
    logic [CNT_W-1:0]     settle_q;
    logic [CNT_W-1:0]     settle_d;
    logic                 locked_s;
    logic                 run_st;
    logic                 ppu_hit;
    logic                 m2_hit;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_LOCK;
            phase_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            settle_q <= settle_d;
        end
    end

    // Lock loss wins over every pause transition; phase only advances in RUN.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        settle_d = settle_q;
        case (state_q)
            WAIT_LOCK: begin
                phase_d  = '0;
                settle_d = '0;
                if (locked_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                phase_d = '0;
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    phase_d = '0;
                end else if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (pause_req) begin
                        state_d = PAUSED;
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            PAUSED: begin
                phase_d = '0;
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (!pause_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = WAIT_LOCK;
                phase_d  = '0;
                settle_d = '0;
            end
        endcase
    end

    // Enables decode straight from the registered state so they track it with no lag.
    assign run_st  = (state_q == RUN);
    assign ppu_hit = ((32'(phase_q) % PPU_DIV) == 32'd0);
    assign m2_hit  = (32'(phase_q) >= M2_RISE);

    assign cpu_ce    = run_st && (phase_q == '0);
    assign ppu_ce    = run_st && ppu_hit;
    assign m2        = run_st && m2_hit;
    assign pause_ack = (state_q == PAUSED);
    assign sys_rst   = (state_q == WAIT_LOCK) || (state_q == SETTLE);
    assign phase     = phase_q;

endmodule

// File: tb/tb_nes_clk_ctrl.sv
// Scoreboard bench for nes_clk_ctrl: a cycle model predicts every output word,
// a monitor compares each one on the falling edge, plus directed milestone checks.
module tb_nes_clk_ctrl;

    localparam int unsigned CPU_DIV = 12;
    localparam int unsigned PPU_DIV = 4;
    localparam int unsigned M2_RISE = 5;
    localparam int unsigned SETTLE  = 16;
    localparam int unsigned PH_W    = $clog2(CPU_DIV);

    localparam int M_WAIT   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_RUN    = 2;
    localparam int M_PAUSE  = 3;

    typedef struct packed {
        logic            sys_rst;
        logic            cpu_ce;
        logic            ppu_ce;
        logic            m2;
        logic            pause_ack;
        logic [PH_W-1:0] phase;
    } obs_t;

    typedef struct {
        int   cyc;
        bit   win;
        obs_t obs;
    } exp_t;

    logic            refclk = 1'b0;
    logic            rst;
    logic            pll_locked;
    logic            pause_req;
    logic            pause_ack;
    logic            sys_rst;
    logic            cpu_ce;
    logic            ppu_ce;
    logic            m2;
    logic [PH_W-1:0] phase;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   win      = 1'b0;
    int   win_len  = 0;
    int   win_cpu  = 0;
    int   win_ppu  = 0;
    int   win_m2   = 0;
    exp_t exp_q[$];

    // Reference model: mode, lock samples seen at each edge, settle count, cycles spent running.
    int          m_mode;
    int unsigned m_settle;
    int unsigned m_runcyc;
    bit          m_samples[$];

    nes_clk_ctrl #(
        .CPU_DIV       (CPU_DIV),
        .PPU_DIV       (PPU_DIV),
        .M2_RISE       (M2_RISE),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .sys_rst    (sys_rst),
        .cpu_ce     (cpu_ce),
        .ppu_ce     (ppu_ce),
        .m2         (m2),
        .phase      (phase)
    );

    always #5 refclk = ~refclk;

    function automatic void model_reset();
        m_mode   = M_WAIT;
        m_settle = 0;
        m_runcyc = 0;
        m_samples.delete();
    endfunction

    function automatic int unsigned model_phase();
        return (m_mode == M_RUN) ? (m_runcyc % CPU_DIV) : 0;
    endfunction

    // Advance the model by one refclk edge using the inputs held across that edge.
    function automatic void model_edge(input bit lk_in, input bit pr);
        bit lk;
        lk = (m_samples.size() >= 2) ? m_samples[m_samples.size() - 2] : 1'b0;
        m_samples.push_back(lk_in);
        if (m_samples.size() > 4) void'(m_samples.pop_front());
        case (m_mode)
            M_WAIT: begin
                if (lk) begin
                    m_mode   = M_SETTLE;
                    m_settle = 0;
                end
            end
            M_SETTLE: begin
                if (!lk) m_mode = M_WAIT;
                else if (m_settle == SETTLE - 1) begin
                    m_mode   = M_RUN;
                    m_runcyc = 0;
                end else m_settle++;
            end
            M_RUN: begin
                if (!lk) m_mode = M_WAIT;
                else if (pr && (m_runcyc % CPU_DIV == CPU_DIV - 1)) m_mode = M_PAUSE;
                else m_runcyc++;
            end
            default: begin
                if (!lk) m_mode = M_WAIT;
                else if (!pr) begin
                    m_mode   = M_RUN;
                    m_runcyc = 0;
                end
            end
        endcase
    endfunction

    function automatic obs_t model_out();
        obs_t        o;
        int unsigned ph;
        bit          running;
        running     = (m_mode == M_RUN);
        ph          = model_phase();
        o.sys_rst   = (m_mode == M_WAIT) || (m_mode == M_SETTLE);
        o.cpu_ce    = running && (ph == 0);
        o.ppu_ce    = running && (ph % PPU_DIV == 0);
        o.m2        = running && (ph >= M2_RISE);
        o.pause_ack = (m_mode == M_PAUSE);
        o.phase     = PH_W'(ph);
        return o;
    endfunction

    task automatic step(input logic lk, input logic pr);
        exp_t e;
        pll_locked = lk;
        pause_req  = pr;
        @(posedge refclk);
        model_edge(lk, pr);
        cyc++;
        e.cyc = cyc;
        e.win = win;
        e.obs = model_out();
        exp_q.push_back(e);
        #2;
    endtask

    task automatic wait_sample();
        @(negedge refclk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sys_rst"},   32'(sys_rst),   1);
        check({tag, "_cpu_ce"},    32'(cpu_ce),    0);
        check({tag, "_ppu_ce"},    32'(ppu_ce),    0);
        check({tag, "_m2"},        32'(m2),        0);
        check({tag, "_pause_ack"}, 32'(pause_ack), 0);
        check({tag, "_phase"},     32'(phase),     0);
    endtask

    // Steps with lock held until the DUT leaves reset; returns the number of steps taken.
    task automatic relock_count(output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0);
            n++;
            wait_sample();
        end while (sys_rst && n < 60);
    endtask

    // Monitor: one expected word per edge, compared on the following falling edge.
    initial begin : monitor
        exp_t e;
        obs_t act;
        forever begin
            @(negedge refclk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {sys_rst, cpu_ce, ppu_ce, m2, pause_ack, phase};
                checks++;
                if (act !== e.obs) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got rst=%b cpu=%b ppu=%b m2=%b ack=%b ph=%0d required rst=%b cpu=%b ppu=%b m2=%b ack=%b ph=%0d",
                             e.cyc, act.sys_rst, act.cpu_ce, act.ppu_ce, act.m2, act.pause_ack, act.phase,
                             e.obs.sys_rst, e.obs.cpu_ce, e.obs.ppu_ce, e.obs.m2, e.obs.pause_ack, e.obs.phase);
                end
                if (e.win) begin
                    win_len++;
                    win_cpu += int'(cpu_ce);
                    win_ppu += int'(ppu_ce);
                    win_m2  += int'(m2);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int drop;
        bit pr;

        rst        = 1'b1;
        pll_locked = 1'b0;
        pause_req  = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(posedge refclk);
        @(posedge refclk);
        #2;
        rst = 1'b0;
        cyc = 0;

        // Lock arrives at edge 10: two sync edges plus sixteen settle edges.
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b0);
        while (cyc < 27) step(1'b1, 1'b0);
        wait_sample();
        check("sys_rst_held_c27", 32'(sys_rst), 1);
        win = 1'b1;
        step(1'b1, 1'b0);
        wait_sample();
        check("release_cycle_28", 32'(sys_rst), 0);
        check("release_cpu_ce", 32'(cpu_ce), 1);
        check("release_ppu_ce", 32'(ppu_ce), 1);
        for (int i = 0; i < 119; i++) step(1'b1, 1'b0);
        win = 1'b0;
        wait_sample();
        check("win_len", win_len, 120);
        check("win_cpu_ce", win_cpu, 10);
        check("win_ppu_ce", win_ppu, 30);
        check("win_m2", win_m2, 70);

        // Pause raised at phase 3 takes effect after phase 11.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        wait_sample();
        check("phase_before_pause", 32'(phase), 3);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        wait_sample();
        check("last_phase_before_pause", 32'(phase), CPU_DIV - 1);
        check("no_ack_yet", 32'(pause_ack), 0);
        step(1'b1, 1'b1);
        wait_sample();
        check("pause_ack", 32'(pause_ack), 1);
        check("paused_cpu_ce", 32'(cpu_ce), 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        wait_sample();
        check("resume_cpu_ce", 32'(cpu_ce), 1);
        check("resume_ack_low", 32'(pause_ack), 0);

        // Lock loss in RUN, then full relock.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        wait_sample();
        check("lockloss_sys_rst", 32'(sys_rst), 1);
        check("lockloss_cpu_ce", 32'(cpu_ce), 0);
        relock_count(n);
        check("relock_from_run", n, 19);

        // Lock dropped for three cycles partway through settling.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        relock_count(n);
        check("relock_mid_settle", n, 19);

        // Asynchronous reset pulse between edges while m2 is high.
        for (int i = 0; i < 2 * CPU_DIV && model_phase() != 7; i++) step(1'b1, 1'b0);
        @(negedge refclk);
        #1;
        check("pre_rst_m2", 32'(m2), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        rst = 1'b0;
        model_reset();
        relock_count(n);
        check("relock_after_rst", n, 19);

        // Random lock glitches and pause toggling.
        drop = 0;
        pr   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (drop > 0) drop--;
            else if ($urandom_range(0, 249) == 0) drop = int'($urandom_range(1, 8));
            if ($urandom_range(0, 14) == 0) pr = !pr;
            step(drop == 0, pr);
        end
        wait_sample();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
